// File: rtl/mips_defines.sv
// Shared definitions for the MIPS core front end: widths, reset vector,
// NOP encoding and the fetch controller state encoding.
package mips_defines;

  localparam int INST_W = 32;
  localparam int ADDR_W = 32;

  localparam logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000;
  localparam logic [INST_W-1:0] NOP      = 32'h0000_0000;

  typedef enum logic {
    S_RESET = 1'b0,
    S_RUN   = 1'b1
  } fetch_state_e;

  // Instruction addresses are word aligned; low bits of any redirect are dropped.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Fetch controller: two-state run/reset FSM, program counter and the
// next-PC selection (flush > stall > branch > sequential).
module pc_reg
  import mips_defines::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_target,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] pc,
  output logic              run
);

  fetch_state_e      state, state_next;
  logic [ADDR_W-1:0] pc_next;

  // State and PC registers; asynchronous reset parks the fetch at RESET_PC.
  // NOTE: registers are written with <= so every flop samples pre-edge values
  // regardless of block ordering; = here would create simulation races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_RESET;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  // Next-state, next-PC and ROM enable decode.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    run        = 1'b0;
    case (state)
      S_RESET: begin
        state_next = S_RUN;
        pc_next    = RESET_PC;
      end
      S_RUN: begin
        run = 1'b1;
        if (flush) begin
          pc_next = word_align(flush_target);
        end else if (!stall) begin
          // While stalled the branch is ignored; ID re-asserts it on release.
          pc_next = branch_flag ? word_align(branch_target) : pc + ADDR_W'(4);
        end
      end
      default: state_next = S_RESET;
    endcase
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: drives the instruction ROM from pc_reg and
// captures fetched instruction plus PC into the IF/ID pipeline register.
module if_stage
  import mips_defines::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_target,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic [INST_W-1:0] ins_input,
  output logic [ADDR_W-1:0] addr_output,
  output logic              enabler_output,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst,
  output logic              id_valid,
  output logic [31:0]       inst_count
);

  logic [ADDR_W-1:0] pc;
  logic              run;

  pc_reg u_pc_reg (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .flush         (flush),
    .flush_target  (flush_target),
    .branch_flag   (branch_flag),
    .branch_target (branch_target),
    .pc            (pc),
    .run           (run)
  );

  assign addr_output    = pc;
  assign enabler_output = run;

  // IF/ID register and delivered-instruction counter. A branch does not
  // squash the current fetch: that word is the delay slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_pc      <= '0;
      id_inst    <= NOP;
      id_valid   <= 1'b0;
      inst_count <= '0;
    end else if (run) begin
      if (flush) begin
        id_pc    <= '0;
        id_inst  <= NOP;
        id_valid <= 1'b0;
      end else if (!stall) begin
        id_pc      <= pc;
        id_inst    <= ins_input;
        id_valid   <= 1'b1;
        inst_count <= inst_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios followed by random
// stall/flush/branch traffic, compared against a cycle-level fetch model.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0, flush = 1'b0, branch_flag = 1'b0;
  logic [31:0] flush_target = '0, branch_target = '0;
  logic [31:0] ins_input;
  logic [31:0] addr_output, id_pc, id_inst, inst_count;
  logic        enabler_output, id_valid;

  int vectors  = 0;
  int failures = 0;

  // Reference model state.
  bit          m_run;
  logic [31:0] m_pc, m_id_pc, m_id_inst, m_cnt;
  bit          m_id_valid;

  if_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .flush          (flush),
    .flush_target   (flush_target),
    .branch_flag    (branch_flag),
    .branch_target  (branch_target),
    .ins_input      (ins_input),
    .addr_output    (addr_output),
    .enabler_output (enabler_output),
    .id_pc          (id_pc),
    .id_inst        (id_inst),
    .id_valid       (id_valid),
    .inst_count     (inst_count)
  );

  always #5 clk = ~clk;

  // Combinational instruction ROM contents.
  function automatic logic [31:0] rom(input logic [31:0] a);
    if (a == 32'h0) return 32'h2001_0005;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign ins_input = rom(addr_output);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_run = 0; m_pc = 32'h0; m_id_pc = 0; m_id_inst = 0; m_id_valid = 0; m_cnt = 0;
  endfunction

  // One clock edge of fetch behaviour, from the stage's architectural rules.
  function automatic void model_edge(bit f, bit s, bit b, logic [31:0] ft, logic [31:0] bt);
    if (!m_run) begin
      m_run = 1;
    end else if (f) begin
      m_pc = ft & ~32'h3;
      m_id_pc = 0; m_id_inst = 0; m_id_valid = 0;
    end else if (!s) begin
      m_id_pc = m_pc; m_id_inst = rom(m_pc); m_id_valid = 1;
      m_cnt = m_cnt + 1;
      m_pc = b ? (bt & ~32'h3) : m_pc + 4;
    end
  endfunction

  task automatic compare_all(input string tag);
    check({tag, ".addr"},  addr_output,           m_pc);
    check({tag, ".en"},    32'(enabler_output),   32'(m_run));
    check({tag, ".pc"},    id_pc,                 m_id_pc);
    check({tag, ".inst"},  id_inst,               m_id_inst);
    check({tag, ".valid"}, 32'(id_valid),         32'(m_id_valid));
    check({tag, ".count"}, inst_count,            m_cnt);
  endtask

  // Apply inputs, take one edge, update the model, sample 1 ns later.
  task automatic step(input string tag, input bit f, input bit s, input bit b,
                      input logic [31:0] ft, input logic [31:0] bt);
    flush = f; stall = s; branch_flag = b; flush_target = ft; branch_target = bt;
    @(posedge clk);
    model_edge(f, s, b, ft, bt);
    #1;
    compare_all(tag);
  endtask

  initial begin
    logic [31:0] cnt_before;
    model_reset();
    #12;
    compare_all("reset");
    rst = 1'b0;

    // Reset release and first delivery.
    step("edge1", 0, 0, 0, 0, 0);
    check("edge1_en", 32'(enabler_output), 32'd1);
    step("edge2", 0, 0, 0, 0, 0);
    check("edge2_inst", id_inst, 32'h2001_0005);
    check("edge2_addr", addr_output, 32'h4);
    check("edge2_count", inst_count, 32'd1);

    // Branch at PC=8 with misaligned target; delay slot delivered.
    step("seq_to8", 0, 0, 0, 0, 0);
    step("branch", 0, 0, 1, 0, 32'h0000_0103);
    check("branch_slot_pc", id_pc, 32'h8);
    check("branch_addr", addr_output, 32'h100);

    for (int i = 0; i < 5; i++) step("seq", 0, 0, 0, 0, 0);

    // Stall with branch asserted, then release with branch still high.
    cnt_before = inst_count;
    for (int i = 0; i < 3; i++) step("stall", 0, 1, 1, 0, 32'h0000_0200);
    check("stall_count", inst_count, cnt_before);
    step("stall_rel", 0, 0, 1, 0, 32'h0000_0200);
    check("stall_rel_addr", addr_output, 32'h200);

    // flush beats stall and branch on the same edge.
    cnt_before = inst_count;
    step("flush_all", 1, 1, 1, 32'h0000_0180, 32'h0000_0400);
    check("flush_addr", addr_output, 32'h180);
    check("flush_count", inst_count, cnt_before);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      step("rand", $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 4) == 0, $urandom(), $urandom());
    end

    // PC wrap at the top of the address space.
    step("to_top", 0, 0, 1, 0, 32'hFFFF_FFFF);
    check("top_addr", addr_output, 32'hFFFF_FFFC);
    step("wrap", 0, 0, 0, 0, 0);
    check("wrap_addr", addr_output, 32'h0);

    // Asynchronous reset mid-cycle, no clock edge involved.
    #2 rst = 1'b1;
    #1;
    model_reset();
    compare_all("async_rst");
    #1 rst = 1'b0;

    step("post_rst1", 0, 0, 0, 0, 0);
    step("post_rst2", 0, 0, 1, 0, 32'h0000_0040);
    for (int i = 0; i < 50; i++) begin
      step("rand2", $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 4) == 0, $urandom(), $urandom());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, failures);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the MIPS core. Owns the program counter, drives the instruction ROM's address and chip-enable, captures the returned instruction together with its PC into the IF/ID pipeline register, and resolves stall, flush and branch-redirect requests from later stages. It sits between the core's decode stage and the combinational instruction ROM at the CPU top level.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  system clock, rising-edge
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- stall  in  1  hold PC and IF/ID contents
- flush  in  1  squash IF/ID, redirect PC to flush_target (exception path)
- flush_target  in  32  exception/redirect vector
- branch_flag  in  1  taken branch/jump resolved in ID
- branch_target  in  32  branch destination
- ins_input  in  32  instruction word from ROM (combinational, valid same cycle as addr_output)
- addr_output  out  32  current PC to ROM
- enabler_output  out  1  ROM chip-enable
- id_pc  out  32  PC of instruction in IF/ID
- id_inst  out  32  instruction in IF/ID
- id_valid  out  1  IF/ID holds a real instruction
- inst_count  out  32  number of instructions delivered to IF/ID

## Operation
- Two-state controller: S_RESET (enabler_output=0) -> S_RUN (enabler_output=1) on first clk edge with rst low; stays in S_RUN until rst.
- In S_RESET: PC held at RESET_PC; IF/ID held as bubble.
- In S_RUN, per edge, priority flush > stall > branch_flag > sequential:
  - flush: PC <= {flush_target[31:2],2'b00}; IF/ID <= bubble (id_valid=0, id_inst=0, id_pc=0).
  - stall: PC, IF/ID, inst_count unchanged. branch_flag ignored (ID holds the branch and re-asserts it).
  - branch_flag: PC <= {branch_target[31:2],2'b00}; IF/ID captures current fetch normally (delay slot is not squashed).
  - sequential: PC <= PC + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0); IF/ID <= {PC, ins_input, 1}.
- inst_count increments by 1 exactly on edges where IF/ID loads with id_valid=1; wraps at 2^32.
- Target low bits [1:0] always forced to zero; no misalignment fault raised.

## Timing
- Reset values: addr_output=RESET_PC, enabler_output=0, id_pc=0, id_inst=0, id_valid=0, inst_count=0; all registers clear immediately on rst rise, independent of clk.
- Edge 1 after rst release: enabler_output->1, PC stays RESET_PC, id_valid stays 0.
- Edge 2: id_pc=RESET_PC, id_inst=ROM[RESET_PC], id_valid=1, PC=RESET_PC+4.
- Fetch-to-ID latency: 1 cycle. Branch redirect: target fetched in the cycle after branch_flag edge; one delay-slot instruction delivered between branch and target.
- Stall held N cycles: outputs frozen N cycles, no instruction lost or duplicated.
- flush and stall together: flush wins. flush and branch_flag together: flush_target wins.
- rst mid-run: returns to S_RESET; pending branch/flush discarded.

## Structure
- Shared package mips_defines: RESET_PC default, NOP word 32'h0000_0000, INST_W=32, ADDR_W=32, state encodings S_RESET/S_RUN.
- One natural sub-module: pc_reg (controller state, PC register, next-PC mux with priority logic). IF/ID register and inst_count stay in if_stage.

## Test plan
- Reset release, ROM[0]=32'h2001_0005 -> edge 1 enabler_output=1, id_valid=0; edge 2 id_pc=0, id_inst=32'h2001_0005, id_valid=1, addr_output=4, inst_count=1.
- Sequential run 5 cycles -> addr_output 4,8,12,16,20; id_pc lags by one cycle; inst_count=5.
- branch_flag=1, branch_target=32'h0000_0103 at PC=8 -> IF/ID gets PC 8 (delay slot), next addr_output=32'h100.
- stall=1 for 3 cycles with branch_flag=1 -> addr_output, id_* and inst_count frozen; on stall release branch_flag still high -> PC=branch_target.
- flush=1, flush_target=32'h0000_0180, stall=1, branch_flag=1 same edge -> addr_output=32'h180, id_valid=0, id_inst=0, inst_count unchanged.
- PC=32'hFFFF_FFFC sequential -> addr_output=0; rst pulse mid-cycle -> enabler_output=0, addr_output=RESET_PC, id_valid=0, inst_count=0 without waiting for clk.
